// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//   Iterative AES-128 encryption controller. It takes one plaintext block per
//   in_valid/in_ready handshake and applies the initial AddRoundKey (round key 0).
//   It then runs NUM_ROUNDS rounds through a single combinational round datapath,
//   one round per clock. Round keys are fetched by index from an external key
//   store. The ciphertext is held on a valid/ready output until it is taken.
//
//   Byte layout: byte 0 of the block is bits [127:120] and byte 15 is bits [7:0].
//   The AES state is column-major, so state[row][col] = byte[row + 4*col].
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      plaintext offered
//   in_ready   out  1      block can be accepted (IDLE and rk_valid)
//   in_data    in   128    plaintext
//   rk_idx     out  CNT_W  round-key index requested this cycle
//   rk_data    in   128    round key for rk_idx, same cycle
//   rk_valid   in   1      rk_data usable; low stalls the sequencer
//   out_valid  out  1      ciphertext valid (DONE)
//   out_ready  in   1      consumer takes ciphertext
//   out_data   out  128    ciphertext (state register)
//   busy       out  1      high in ROUND or DONE
//   abort      in   1      only when AES_SEQ_ABORT_EN is defined; returns to IDLE
//
// Configuration macro: AES_SEQ_ABORT_EN (adds the abort port).
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic [CNT_W-1:0] rk_idx,
  input  logic [127:0]     rk_data,
  input  logic             rk_valid,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef AES_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [127:0]     out_data,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[2047 - 8 * int'(x) -: 8];
  endfunction

  // Multiply by {02} in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } fsm_t;

  fsm_t             fsm_reg, fsm_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [127:0]     data_reg, data_next;

  // ---------------------------------------------------------------------
  // One AES round on data_reg with rk_data: SubBytes, ShiftRows,
  // MixColumns (skipped in the last round), AddRoundKey.
  // ---------------------------------------------------------------------
  logic [7:0]   sb_byte [16];
  logic [7:0]   sr_byte [16];
  logic [7:0]   mc_byte [16];
  logic [127:0] cipher_state;
  logic         last_round;

  assign last_round = (cnt_reg == LAST_CNT);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sub_shift
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      // Row r rotates left by r columns.
      localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
      assign sb_byte[gi] = sbox(data_reg[127-8*gi -: 8]);
      assign sr_byte[gi] = sb_byte[SRC];
    end

    for (gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr_byte[4*gi + 0];
      assign a1 = sr_byte[4*gi + 1];
      assign a2 = sr_byte[4*gi + 2];
      assign a3 = sr_byte[4*gi + 3];
      assign mc_byte[4*gi + 0] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      assign mc_byte[4*gi + 1] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      assign mc_byte[4*gi + 2] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      assign mc_byte[4*gi + 3] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    end

    for (gi = 0; gi < 16; gi++) begin : g_add_key
      assign cipher_state[127-8*gi -: 8] =
        (last_round ? sr_byte[gi] : mc_byte[gi]) ^ rk_data[127-8*gi -: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg  <= S_IDLE;
      cnt_reg  <= '0;
      data_reg <= '0;
    end else begin
      fsm_reg  <= fsm_next;
      cnt_reg  <= cnt_next;
      data_reg <= data_next;
    end
  end

  always_comb begin
    fsm_next  = fsm_reg;
    cnt_next  = cnt_reg;
    data_next = data_reg;
    in_ready  = 1'b0;
    rk_idx    = '0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (fsm_reg)
      S_IDLE: begin
        // Key 0 must be present to do the initial AddRoundKey on accept.
        in_ready = rk_valid;
        if (in_valid && rk_valid) begin
          data_next = in_data ^ rk_data;
          cnt_next  = ONE_CNT;
          fsm_next  = S_ROUND;
        end
      end
      S_ROUND: begin
        busy   = 1'b1;
        rk_idx = cnt_reg;
        // Without a usable key nothing moves; the round is simply retried.
        if (rk_valid) begin
          data_next = cipher_state;
          if (last_round) begin
            cnt_next = '0;
            fsm_next = S_DONE;
          end else begin
            cnt_next = cnt_reg + ONE_CNT;
          end
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_next = S_IDLE;
        end
      end
      default: begin
        fsm_next = S_IDLE;
        cnt_next = '0;
      end
    endcase

`ifdef AES_SEQ_ABORT_EN
    // Abort wins over both round progress and out_ready; the state register
    // keeps its contents.
    if (abort && (fsm_reg != S_IDLE)) begin
      fsm_next  = S_IDLE;
      cnt_next  = '0;
      data_next = data_reg;
    end
`endif
  end

  assign out_data = data_reg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
module tb_aes_round_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         rk_valid;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
`ifdef AES_SEQ_ABORT_EN
  logic         abort;
`endif

  int checks   = 0;
  int failures = 0;

  // FIPS-197 key expansion of 2b7e151628aed2a6abf7158809cf4f3c.
  logic [127:0] rk_tab [0:10];

  assign rk_data = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : 128'h0;

  always #5 clk = ~clk;

  aes_round_sequencer #(.NUM_ROUNDS(10), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .rk_valid  (rk_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef AES_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .out_data  (out_data),
    .busy      (busy)
  );

  localparam logic [127:0] PT_A = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_A = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT_B = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT_C = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT_C = 128'hf5d3d58503b9699de785895a96fdbaaf;

  task automatic chk(input logic [127:0] obs, input logic [127:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one block, optionally stall at one round, optionally hold DONE.
  task automatic encrypt(input logic [127:0] pt, input logic [127:0] ct,
                         input int stall_at, input int stall_len, input int hold_done,
                         input string name);
    int edges;
    int exp_idx;
    int stalls;
    logic [127:0] frozen;
    frozen    = '0;
    out_ready = (hold_done == 0);
    in_data   = pt;
    in_valid  = 1'b1;
    edges = 0;
    while (!in_ready && edges < 50) begin
      tick();
      edges++;
    end
    chk(in_ready, 1'b1, {name, "_in_ready"});
    chk(rk_idx, 4'd0, {name, "_rk_idx_idle"});
    tick();
    in_valid = 1'b0;
    edges   = 1;
    exp_idx = 1;
    stalls  = 0;
    while (!out_valid && edges < 60) begin
      chk(rk_idx, exp_idx, {name, "_rk_idx"});
      chk(busy, 1'b1, {name, "_busy"});
      chk(in_ready, 1'b0, {name, "_in_ready_round"});
      if (exp_idx == stall_at && stalls < stall_len) begin
        if (stalls == 0) frozen = out_data;
        else chk(out_data, frozen, {name, "_stall_frozen"});
        rk_valid = 1'b0;
        stalls++;
      end else begin
        if (stall_len > 0 && stalls == stall_len) begin
          chk(out_data, frozen, {name, "_stall_frozen"});
          stalls++;
        end
        rk_valid = 1'b1;
        exp_idx++;
      end
      tick();
      edges++;
    end
    rk_valid = 1'b1;
    chk(out_valid, 1'b1, {name, "_out_valid"});
    chk(edges, 11 + stall_len, {name, "_latency_edges"});
    chk(out_data, ct, {name, "_ciphertext"});
    for (int i = 0; i < hold_done; i++) begin
      tick();
      chk(out_valid, 1'b1, {name, "_hold_valid"});
      chk(out_data, ct, {name, "_hold_data"});
      chk(in_ready, 1'b0, {name, "_hold_in_ready"});
    end
    out_ready = 1'b1;
    tick();
    chk(out_valid, 1'b0, {name, "_idle_out_valid"});
    chk(busy, 1'b0, {name, "_idle_busy"});
    out_ready = 1'b0;
    $display("txn %s pt=%h ct=%h edges=%0d", name, pt, out_data, edges);
  endtask

  initial begin
    int acc_t [3];
    logic [127:0] ct_seen [2];
    int n_acc;
    int n_ct;
    int guard;

    rk_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    rk_valid  = 1'b1;
    out_ready = 1'b0;
`ifdef AES_SEQ_ABORT_EN
    abort     = 1'b0;
`endif

    // Reset state
    #12;
    chk(out_valid, 1'b0, "reset_out_valid");
    chk(busy, 1'b0, "reset_busy");
    chk(rk_idx, 4'd0, "reset_rk_idx");
    chk(out_data, 128'h0, "reset_out_data");
    tick();
    rst_n = 1'b1;
    tick();
    chk(in_ready, 1'b1, "post_reset_in_ready");
    $display("txn reset done");

    // No key available in IDLE: not ready, and an offered block is not taken.
    rk_valid = 1'b0;
    in_valid = 1'b1;
    in_data  = PT_A;
    #1;
    chk(in_ready, 1'b0, "idle_no_key_in_ready");
    tick();
    chk(busy, 1'b0, "idle_no_key_busy");
    in_valid = 1'b0;
    rk_valid = 1'b1;
    $display("txn idle_rk_valid_low");

    // 1: FIPS-197 vector; out_ready high before out_valid is ignored.
    encrypt(PT_A, CT_A, 0, 0, 0, "fips197");
    // 2: three stall cycles at round 5
    encrypt(PT_A, CT_A, 5, 3, 0, "stall_r5");
    // 3: consumer holds off 20 cycles
    encrypt(PT_B, CT_B, 0, 0, 20, "hold_done");

    // 4: back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = PT_B;
    n_acc = 0;
    n_ct  = 0;
    acc_t = '{0, 0, 0};
    ct_seen = '{128'h0, 128'h0};
    for (int c = 0; c < 60 && n_acc < 3; c++) begin
      if (in_ready && in_valid) begin
        acc_t[n_acc] = c;
        n_acc++;
        if (n_acc == 3) in_valid = 1'b0;
      end
      if (out_valid && n_ct < 2) begin
        ct_seen[n_ct] = out_data;
        n_ct++;
      end
      tick();
      if (n_acc == 1) in_data = PT_C;
    end
    in_valid = 1'b0;
    chk(n_acc, 3, "b2b_accept_count");
    chk(acc_t[1] - acc_t[0], 12, "b2b_period_1");
    chk(acc_t[2] - acc_t[1], 12, "b2b_period_2");
    chk(ct_seen[0], CT_B, "b2b_ct_first");
    chk(ct_seen[1], CT_C, "b2b_ct_second");
    $display("txn back_to_back accepts=%0d,%0d,%0d ct0=%h ct1=%h",
             acc_t[0], acc_t[1], acc_t[2], ct_seen[0], ct_seen[1]);
    guard = 0;
    while (busy && guard < 30) begin
      tick();
      guard++;
    end
    chk(busy, 1'b0, "b2b_drain_idle");
    out_ready = 1'b0;

    // 5: reset pulse at round 4
    in_data  = PT_C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (rk_idx != 4'd4 && guard < 20) begin
      tick();
      guard++;
    end
    chk(rk_idx, 4'd4, "rst_mid_reach_r4");
    rst_n = 1'b0;
    #1;
    chk(out_valid, 1'b0, "rst_mid_out_valid");
    chk(busy, 1'b0, "rst_mid_busy");
    chk(out_data, 128'h0, "rst_mid_state");
    tick();
    rst_n = 1'b1;
    tick();
    chk(in_ready, 1'b1, "rst_mid_in_ready");
    $display("txn reset_mid_round");
    encrypt(PT_C, CT_C, 0, 0, 0, "after_reset");

`ifdef AES_SEQ_ABORT_EN
    // 6: abort at round 7
    in_data  = PT_B;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (rk_idx != 4'd7 && guard < 20) begin
      tick();
      guard++;
    end
    chk(rk_idx, 4'd7, "abort_reach_r7");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk(busy, 1'b0, "abort_busy");
    chk(rk_idx, 4'd0, "abort_rk_idx");
    for (int i = 0; i < 12; i++) begin
      chk(out_valid, 1'b0, "abort_no_out_valid");
      tick();
    end
    $display("txn abort_round7");
    encrypt(PT_A, CT_A, 0, 0, 0, "after_abort");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
